// File: rtl/audio_seq_multi_if.sv
// Bundle of game-logic controls and ROM-address outputs for the multi-channel audio sequencer.
interface audio_seq_multi_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 17,
    parameter int DIV_W  = 16
) ();
    logic                     INIT_FINISH;
    logic                     sample_en;
    logic [NUM_CH-1:0]        trigger;
    logic [NUM_CH-1:0]        stop;
    logic [NUM_CH-1:0]        loop_en;
    logic [NUM_CH*ADDR_W-1:0] start_addr;
    logic [NUM_CH*ADDR_W-1:0] length;
    logic [NUM_CH*DIV_W-1:0]  rate_div;

    logic                     INIT_BGM;
    logic [NUM_CH*ADDR_W-1:0] Add;
    logic [NUM_CH-1:0]        active;
    logic [NUM_CH-1:0]        done;

    modport master (
        output INIT_FINISH, sample_en, trigger, stop, loop_en, start_addr, length, rate_div,
        input  INIT_BGM, Add, active, done
    );

    modport slave (
        input  INIT_FINISH, sample_en, trigger, stop, loop_en, start_addr, length, rate_div,
        output INIT_BGM, Add, active, done
    );
endinterface

// File: rtl/audio_seq_multi.sv
// Multi-channel sample-address sequencer: per-channel one-shot/loop playback with
// a sample_en-gated rate divider, all held idle until codec init completes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// G_WAIT    | codec init pending; trigger/stop ignored, channels idle
// G_RUN     | init done; channels respond to trigger/stop (terminal)
// CH_IDLE   | channel silent; Add holds latched start address
// CH_PLAY   | channel stepping offset through [0, length-1]
module audio_seq_multi #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 17,
    parameter int DIV_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    audio_seq_multi_if.slave  bus
);

    typedef enum logic {G_WAIT = 1'b0, G_RUN = 1'b1} g_state_e;
    typedef enum logic {CH_IDLE = 1'b0, CH_PLAY = 1'b1} ch_state_e;

    g_state_e g_state_q, g_state_d;
    logic     init_bgm_q, init_bgm_d;
    logic     run;

    logic [NUM_CH*ADDR_W-1:0] add_all;
    logic [NUM_CH-1:0]        active_all;
    logic [NUM_CH-1:0]        done_all;

    always_comb begin
        g_state_d  = g_state_q;
        init_bgm_d = 1'b1;
        if (g_state_q == G_WAIT && bus.INIT_FINISH) begin
            g_state_d = G_RUN;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            g_state_q  <= G_WAIT;
            init_bgm_q <= 1'b0;
        end else begin
            g_state_q  <= g_state_d;
            init_bgm_q <= init_bgm_d;
        end
    end

    assign run = (g_state_q == G_RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e         state_q, state_d;
        logic [DIV_W-1:0]  div_q, div_d;
        logic [DIV_W-1:0]  rate_q, rate_d;
        logic [ADDR_W-1:0] offset_q, offset_d;
        logic [ADDR_W-1:0] start_q, start_d;
        logic [ADDR_W-1:0] len_q, len_d;
        logic [ADDR_W-1:0] add_q, add_d;
        logic              loop_q, loop_d;
        logic              done_q, done_d;

        logic [ADDR_W-1:0] start_in;
        logic [ADDR_W-1:0] len_in;
        logic [DIV_W-1:0]  rate_in;
        logic [ADDR_W:0]   off_inc;

        assign start_in = bus.start_addr[i*ADDR_W +: ADDR_W];
        assign len_in   = bus.length[i*ADDR_W +: ADDR_W];
        assign rate_in  = bus.rate_div[i*DIV_W +: DIV_W];

        // stop beats trigger beats step; stop also masks a same-cycle trigger
        always_comb begin
            state_d  = state_q;
            div_d    = div_q;
            rate_d   = rate_q;
            offset_d = offset_q;
            start_d  = start_q;
            len_d    = len_q;
            loop_d   = loop_q;
            done_d   = 1'b0;
            off_inc  = {1'b0, offset_q} + {{ADDR_W{1'b0}}, 1'b1};

            if (run && bus.stop[i]) begin
                if (state_q == CH_PLAY) begin
                    state_d  = CH_IDLE;
                    offset_d = '0;
                    done_d   = 1'b1;
                end
            end else if (run && bus.trigger[i]) begin
                if (len_in != '0) begin
                    start_d  = start_in;
                    len_d    = len_in;
                    rate_d   = rate_in;
                    loop_d   = bus.loop_en[i];
                    div_d    = '0;
                    offset_d = '0;
                    state_d  = CH_PLAY;
                end
            end else if (state_q == CH_PLAY && bus.sample_en) begin
                if (div_q == rate_q) begin
                    div_d = '0;
                    if (off_inc < {1'b0, len_q}) begin
                        offset_d = off_inc[ADDR_W-1:0];
                    end else begin
                        offset_d = '0;
                        if (!loop_q) begin
                            state_d = CH_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            // Address wraps modulo 2^ADDR_W by truncation
            add_d = start_d + offset_d;
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state_q  <= CH_IDLE;
                div_q    <= '0;
                rate_q   <= '0;
                offset_q <= '0;
                start_q  <= '0;
                len_q    <= '0;
                loop_q   <= 1'b0;
                done_q   <= 1'b0;
                add_q    <= '0;
            end else begin
                state_q  <= state_d;
                div_q    <= div_d;
                rate_q   <= rate_d;
                offset_q <= offset_d;
                start_q  <= start_d;
                len_q    <= len_d;
                loop_q   <= loop_d;
                done_q   <= done_d;
                add_q    <= add_d;
            end
        end

        assign add_all[i*ADDR_W +: ADDR_W] = add_q;
        assign active_all[i]               = (state_q == CH_PLAY);
        assign done_all[i]                 = done_q;
    end

    assign bus.INIT_BGM = init_bgm_q;
    assign bus.Add      = add_all;
    assign bus.active   = active_all;
    assign bus.done     = done_all;

endmodule

// File: tb/tb_audio_seq_multi.sv
// Directed bench for audio_seq_multi: expectations queued at stimulus time, popped after each edge.
module tb_audio_seq_multi;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 17;
    localparam int DIV_W  = 16;

    logic Clk;
    logic Reset;

    audio_seq_multi_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

    audio_seq_multi #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // sel: 0/1 Add ch0/ch1, 2/3 active ch0/ch1, 4/5 done ch0/ch1, 6 INIT_BGM, 7 done vector
    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return 32'(bus.Add[0 +: ADDR_W]);
            1:       return 32'(bus.Add[ADDR_W +: ADDR_W]);
            2:       return 32'(bus.active[0]);
            3:       return 32'(bus.active[1]);
            4:       return 32'(bus.done[0]);
            5:       return 32'(bus.done[1]);
            6:       return 32'(bus.INIT_BGM);
            default: return 32'(bus.done);
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(string tag, int sel, logic [31:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic exp_ch(int ch, string tag, logic [31:0] add, logic act, logic dn);
        push({tag, "_add"}, ch, add);
        push({tag, "_active"}, 2 + ch, 32'(act));
        push({tag, "_done"}, 4 + ch, 32'(dn));
    endtask

    task automatic compare_all();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] o;
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic adv();
        tick();
        compare_all();
    endtask

    task automatic pulse(logic [NUM_CH-1:0] trg, logic [NUM_CH-1:0] stp);
        bus.trigger = trg;
        bus.stop    = stp;
        tick();
        bus.trigger = '0;
        bus.stop    = '0;
        compare_all();
    endtask

    task automatic set_cfg(int ch, logic [ADDR_W-1:0] st, logic [ADDR_W-1:0] len,
                           logic [DIV_W-1:0] rd, logic lp);
        bus.start_addr[ch*ADDR_W +: ADDR_W] = st;
        bus.length[ch*ADDR_W +: ADDR_W]     = len;
        bus.rate_div[ch*DIV_W +: DIV_W]     = rd;
        bus.loop_en[ch]                     = lp;
    endtask

    initial begin
        Reset           = 1'b1;
        bus.INIT_FINISH = 1'b0;
        bus.sample_en   = 1'b0;
        bus.trigger     = '0;
        bus.stop        = '0;
        bus.loop_en     = '0;
        bus.start_addr  = '0;
        bus.length      = '0;
        bus.rate_div    = '0;

        tick();
        push("rst_add0", 0, 0);
        push("rst_add1", 1, 0);
        push("rst_act0", 2, 0);
        push("rst_act1", 3, 0);
        push("rst_done", 7, 0);
        push("rst_init", 6, 0);
        compare_all();

        #2 Reset = 1'b0;
        push("init_bgm_rise", 6, 1);
        adv();

        // Triggers while waiting for codec init are ignored
        set_cfg(0, 17'd100, 17'd4, 16'd2, 1'b0);
        exp_ch(0, "wait_trig", 0, 1'b0, 1'b0);
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 9; k++) begin
            push($sformatf("wait_idle%0d", k), 2, 0);
            adv();
        end

        bus.INIT_FINISH = 1'b1;
        bus.sample_en   = 1'b1;
        adv();

        // One-shot: 4 samples, each held rate_div+1 = 3 cycles
        exp_ch(0, "os_k0", 100, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        for (int k = 1; k <= 13; k++) begin
            if (k < 12)       exp_ch(0, $sformatf("os_k%0d", k), 32'(100 + k / 3), 1'b1, 1'b0);
            else if (k == 12) exp_ch(0, "os_end", 100, 1'b0, 1'b1);
            else              exp_ch(0, "os_after", 100, 1'b0, 1'b0);
            adv();
        end

        // Looping channel wrapping across the top of the address space
        set_cfg(1, 17'h1FFFE, 17'd3, 16'd0, 1'b1);
        exp_ch(1, "loop_k0", 32'h1FFFE, 1'b1, 1'b0);
        pulse(2'b10, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            exp_ch(1, $sformatf("loop_k%0d", k), (32'h1FFFE + 32'(k % 3)) & 32'h1FFFF, 1'b1, 1'b0);
            adv();
        end
        exp_ch(1, "stop1", 32'h1FFFE, 1'b0, 1'b1);
        pulse(2'b00, 2'b10);
        exp_ch(1, "stop1_after", 32'h1FFFE, 1'b0, 1'b0);
        adv();

        // sample_en toggling with rate_div = 1: each address held 4 clocks
        set_cfg(0, 17'd200, 17'd3, 16'd1, 1'b0);
        exp_ch(0, "tog_k0", 200, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        bus.sample_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k < 12) exp_ch(0, $sformatf("tog_k%0d", k), 32'(200 + k / 4), 1'b1, 1'b0);
            else        exp_ch(0, "tog_end", 200, 1'b0, 1'b1);
            adv();
            bus.sample_en = (k % 2 == 1);
        end
        bus.sample_en = 1'b1;

        // stop and trigger together: stop wins
        set_cfg(0, 17'd300, 17'd5, 16'd0, 1'b1);
        exp_ch(0, "st_a", 300, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        exp_ch(0, "st_b", 301, 1'b1, 1'b0);
        adv();
        set_cfg(0, 17'd400, 17'd5, 16'd0, 1'b1);
        exp_ch(0, "stop_trig", 300, 1'b0, 1'b1);
        pulse(2'b01, 2'b01);

        set_cfg(0, 17'd500, 17'd0, 16'd0, 1'b0);
        exp_ch(0, "len0", 300, 1'b0, 1'b0);
        pulse(2'b01, 2'b00);

        // Mid-play retrigger restarts without done
        set_cfg(0, 17'd300, 17'd5, 16'd0, 1'b1);
        exp_ch(0, "rt_a", 300, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        exp_ch(0, "rt_b", 301, 1'b1, 1'b0);
        adv();
        exp_ch(0, "rt_c", 302, 1'b1, 1'b0);
        adv();
        set_cfg(0, 17'd600, 17'd5, 16'd0, 1'b1);
        exp_ch(0, "retrig", 600, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        exp_ch(0, "retrig_b", 601, 1'b1, 1'b0);
        adv();

        // Both channels triggered together and finishing together
        set_cfg(0, 17'd700, 17'd2, 16'd0, 1'b0);
        set_cfg(1, 17'd10, 17'd2, 16'd0, 1'b0);
        exp_ch(0, "dual0_a", 700, 1'b1, 1'b0);
        exp_ch(1, "dual1_a", 10, 1'b1, 1'b0);
        pulse(2'b11, 2'b00);
        exp_ch(0, "dual0_b", 701, 1'b1, 1'b0);
        exp_ch(1, "dual1_b", 11, 1'b1, 1'b0);
        adv();
        push("dual_done", 7, 3);
        exp_ch(0, "dual0_c", 700, 1'b0, 1'b1);
        exp_ch(1, "dual1_c", 10, 1'b0, 1'b1);
        adv();
        push("dual_done_clr", 7, 0);
        adv();

        // Asynchronous reset between edges during playback
        set_cfg(0, 17'd800, 17'd10, 16'd0, 1'b1);
        exp_ch(0, "pre_rst_a", 800, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);
        exp_ch(0, "pre_rst_b", 801, 1'b1, 1'b0);
        adv();
        #2 Reset = 1'b1;
        #1;
        push("arst_add0", 0, 0);
        push("arst_add1", 1, 0);
        push("arst_act0", 2, 0);
        push("arst_act1", 3, 0);
        push("arst_done", 7, 0);
        push("arst_init", 6, 0);
        compare_all();
        bus.INIT_FINISH = 1'b0;
        push("arst_hold_init", 6, 0);
        push("arst_hold_act0", 2, 0);
        adv();
        Reset = 1'b0;

        set_cfg(0, 17'd900, 17'd3, 16'd0, 1'b0);
        push("rewait_init", 6, 1);
        exp_ch(0, "rewait_ignored", 0, 1'b0, 1'b0);
        pulse(2'b01, 2'b00);
        bus.INIT_FINISH = 1'b1;
        adv();
        exp_ch(0, "rewait_play", 900, 1'b1, 1'b0);
        pulse(2'b01, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_seq_multi.md
Name: audio_seq_multi

Overview:
- Parametrised multi-channel sample-address sequencer for the on-board audio path; successor to the single-channel BGM address counter.
- Sits between game logic (trigger/stop per sound) and sample ROM readers: one ROM address per channel, one-shot or looping playback, per-channel rate divider.
- Holds all channels idle until codec initialisation completes.

Parameters:
- NUM_CH, 2, number of independent channels (ch0 = BGM, ch1.. = effects)
- ADDR_W, 17, sample ROM address width
- DIV_W, 16, rate-divider width

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- INIT_FINISH  in  1  codec init done; level, sampled each cycle
- sample_en  in  1  sample-consumed strobe from codec interface; gates all dividers
- trigger  in  NUM_CH  per-channel start/restart pulse
- stop  in  NUM_CH  per-channel stop pulse
- loop_en  in  NUM_CH  loop mode, latched on trigger
- start_addr  in  NUM_CH*ADDR_W  packed start addresses, ch i at [i*ADDR_W +: ADDR_W], latched on trigger
- length  in  NUM_CH*ADDR_W  packed sample counts, latched on trigger
- rate_div  in  NUM_CH*DIV_W  packed divider terminal values, latched on trigger
- INIT_BGM  out  1  codec init request
- Add  out  NUM_CH*ADDR_W  packed registered ROM addresses
- active  out  NUM_CH  channel playing
- done  out  NUM_CH  one-cycle pulse at one-shot completion or stop

Behaviour:
- Reset: global state WAIT. All Add = 0, active = 0, done = 0, INIT_BGM = 0. All dividers, offsets and latched config = 0. Asynchronous; mid-playback reset clears immediately.
- INIT_BGM: registered. Goes 1 on the first Clk edge after Reset deasserts and stays 1 until the next Reset.
- Global FSM:
  - WAIT -> RUN on a cycle with INIT_FINISH = 1.
  - RUN is terminal until Reset.
  - In WAIT, trigger and stop are ignored.
- Per-channel FSM IDLE/PLAY (active = 1 in PLAY). Registers: div_cnt[DIV_W], offset[ADDR_W].
- Trigger in RUN with latched-candidate length != 0:
  - Latch start_addr, length, loop_en, rate_div.
  - div_cnt = 0, offset = 0, go PLAY.
  - Add = start_addr on the next cycle (1-cycle latency).
- Trigger with length = 0: ignored. State unchanged, no done.
- Trigger while PLAY: restart as above, with no done pulse.
- Divider, PLAY only:
  - On a cycle with sample_en = 1: if div_cnt == rate_div then div_cnt = 0 and step = 1; else div_cnt + 1.
  - sample_en = 0: div_cnt holds.
  - Result: one step per (rate_div+1) sample_en cycles. rate_div = 0 steps on every sample_en.
- Step:
  - If offset < length-1: offset + 1.
  - Else, loop = 1: offset = 0, stay PLAY.
  - Else, loop = 0: offset = 0, go IDLE, done pulse next cycle.
- Add = latched start + offset, modulo 2^ADDR_W (wraps silently). In IDLE, Add holds latched start.
- stop in PLAY: go IDLE, offset = 0, done pulse. stop in IDLE: no effect.
- Priority on the same channel and cycle: stop > trigger > step.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

Test Plan:
- Reset release, INIT_FINISH = 0 for 10 cycles with trigger[0] pulsed -> INIT_BGM = 1 from cycle 1; active = 0, Add = 0. Raise INIT_FINISH, trigger ch0 -> active[0] = 1 next cycle.
- ch0: start = 100, length = 4, rate_div = 2, loop = 0, sample_en always 1 -> Add = 100, 101, 102, 103, each held 3 cycles. Then active[0] = 0, done[0] pulses exactly once, Add = 100.
- ch1: loop = 1, start = 0x1FFFE, length = 3, rate_div = 0 -> Add sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x1FFFE...; done never pulses.
- sample_en toggling 1/0 with rate_div = 1 -> each address held 4 clocks; div_cnt frozen while sample_en = 0.
- Same cycle on ch0: stop + trigger -> IDLE, done pulse. Trigger with length = 0 -> no change. Mid-play retrigger -> Add returns to new start, no done.
- Assert Reset asynchronously mid-playback, between edges -> Add, active, done, INIT_BGM = 0 before the next Clk edge. Sequencer re-waits for INIT_FINISH.
